neuron_mac_param: RTL

Parametrised single-neuron processing element for the hardware ANN. It computes out = act(sat((sum of w[i]*inp[i] + (bias << OUT_SHIFT)) >>> OUT_SHIFT)) over N_INPUTS signed operands. The block is the generalised successor of the fixed 8-input, 8-bit neuron, with configurable input count, data width, MAC lanes per cycle, output scaling and a run-time activation mode. Layer controllers instantiate one per neuron and sequence it with start/finish.

---
 rtl/neuron_mac_param.sv | 135 +++++++++++++
 1 files changed

// File: rtl/neuron_mac_param.sv
// neuron_mac_param: parametrised single-neuron MAC with bias, fixed-point scaling,
// optional ReLU and output saturation. Sequenced by start/finish.
`default_nettype none

module neuron_mac_param #(
  parameter int N_INPUTS  = 8,
  parameter int DATA_W    = 8,
  parameter int LANES     = 1,
  parameter int OUT_SHIFT = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [N_INPUTS*DATA_W-1:0]   w,
  input  logic [N_INPUTS*DATA_W-1:0]   inp,
  input  logic [DATA_W-1:0]            bias,
  input  logic                         act_mode,
  output logic                         busy,
  output logic                         finish,
  output logic [DATA_W-1:0]            out
);

  localparam int ACC_W = 2*DATA_W + $clog2(N_INPUTS) + OUT_SHIFT + 2;
  localparam int IDX_W = $clog2(N_INPUTS) + 1;
  localparam logic [IDX_W-1:0] C_LAST = IDX_W'(N_INPUTS - LANES);
  localparam logic [IDX_W-1:0] C_STEP = IDX_W'(LANES);
  localparam logic signed [ACC_W-1:0] C_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] C_MIN = ~C_MAX;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_MAC = 2'd1, S_DONE = 2'd2} state_t;

  state_t                       r_state;
  state_t                       w_next;
  logic [N_INPUTS*DATA_W-1:0]   r_w;
  logic [N_INPUTS*DATA_W-1:0]   r_inp;
  logic                         r_act;
  logic signed [ACC_W-1:0]      r_acc;
  logic [IDX_W-1:0]             r_idx;
  logic                         r_finish;
  logic [DATA_W-1:0]            r_out;

  logic signed [2*DATA_W-1:0]   w_prod [LANES];
  logic signed [ACC_W-1:0]      w_lane_sum;
  logic signed [ACC_W-1:0]      w_shift;
  logic signed [ACC_W-1:0]      w_relu;
  logic [DATA_W-1:0]            w_sat;

  // Operand registers shift down each MAC cycle, so the lanes always read the low elements.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign w_prod[l] = $signed(r_w[l*DATA_W +: DATA_W]) * $signed(r_inp[l*DATA_W +: DATA_W]);
  end

  always_comb begin
    w_lane_sum = '0;
    for (int l = 0; l < LANES; l++) begin
      w_lane_sum = w_lane_sum + ACC_W'(w_prod[l]);
    end
  end

  always_comb begin
    w_shift = r_acc >>> OUT_SHIFT;
    w_relu  = (r_act && w_shift[ACC_W-1]) ? '0 : w_shift;
    if (w_relu > C_MAX) begin
      w_sat = C_MAX[DATA_W-1:0];
    end else if (w_relu < C_MIN) begin
      w_sat = C_MIN[DATA_W-1:0];
    end else begin
      w_sat = w_relu[DATA_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    busy   = 1'b1;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) w_next = S_MAC;
      end
      S_MAC:   if (r_idx == C_LAST) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_w      <= '0;
      r_inp    <= '0;
      r_act    <= 1'b0;
      r_acc    <= '0;
      r_idx    <= '0;
      r_finish <= 1'b0;
      r_out    <= '0;
    end else begin
      r_finish <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_w   <= w;
            r_inp <= inp;
            r_act <= act_mode;
            r_acc <= ACC_W'($signed(bias)) <<< OUT_SHIFT;
            r_idx <= '0;
          end
        end
        S_MAC: begin
          r_acc <= r_acc + w_lane_sum;
          r_idx <= r_idx + C_STEP;
          r_w   <= r_w >> (LANES*DATA_W);
          r_inp <= r_inp >> (LANES*DATA_W);
        end
        S_DONE: begin
          r_out    <= w_sat;
          r_finish <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign finish = r_finish;
  assign out    = r_out;

endmodule

`default_nettype wire
